// File: rtl/cpu_prog_streamer.sv
// cpu_prog_streamer: resets the cpu, streams a stored program of 12-bit
// instruction words onto its data_in and captures every change of its
// 8-bit data_out into a small result FIFO.
module cpu_prog_streamer #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int HOLD_CYCLES = 10,
  parameter int RST_CYCLES  = 10,
  parameter int RES_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              n_Rst,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [11:0]       load_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  output logic              cpu_n_Rst,
  output logic [11:0]       instr_out,
  input  logic [7:0]        cpu_data_out,
  output logic [7:0]        res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int RES_AW = $clog2(RES_DEPTH);
  localparam int PH_MAX = (HOLD_CYCLES > RST_CYCLES) ? HOLD_CYCLES : RST_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0]   HOLD_LAST = PH_W'(HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0]   RST_LAST  = PH_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W+1)'(DEPTH);
  localparam logic [RES_AW:0]   RES_FULL  = (RES_AW+1)'(RES_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_PRE, S_ISSUE, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [7:0]          prev_q, prev_d;
  logic                cpu_n_rst_q, cpu_n_rst_d;
  logic [11:0]         instr_q, instr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic [RES_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [RES_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [RES_AW:0]     count_q, count_d;
  logic [7:0]          res_data_q, res_data_d;
  logic                res_valid_q, res_valid_d;

  logic [11:0]         prog_mem_q [DEPTH];
  logic [7:0]          fifo_mem_q [RES_DEPTH];

  logic flush, push, pop, full, push_ok, prog_we;

  // Sequencer: next state, phase counter, word index and latched length
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    len_d   = len_q;
    flush   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RST;
          phase_d = '0;
          flush   = 1'b1;
          len_d   = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
        end
      end
      S_RST: begin
        if (phase_q == RST_LAST) begin
          state_d = S_PRE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_PRE: begin
        if (phase_q == HOLD_LAST) begin
          phase_d = '0;
          idx_d   = '0;
          state_d = (len_q != '0) ? S_ISSUE : S_DRAIN;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_ISSUE: begin
        if (phase_q == HOLD_LAST) begin
          phase_d = '0;
          if ({1'b0, idx_q} == len_q - (ADDR_W+1)'(1)) begin
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_DRAIN: begin
        if (phase_q == HOLD_LAST) begin
          state_d = S_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Change detector on cpu_data_out; previous value cleared while in RST
  always_comb begin
    push   = (state_q == S_PRE || state_q == S_ISSUE || state_q == S_DRAIN) &&
             (cpu_data_out != prev_q);
    prev_d = prev_q;
    if (state_q == S_RST) begin
      prev_d = '0;
    end else if (push) begin
      prev_d = cpu_data_out;
    end
  end

  // Result FIFO pointers, occupancy, sticky overflow and registered head
  always_comb begin
    pop      = res_valid_q && res_ready;
    full     = (count_q == RES_FULL);
    push_ok  = push && (!full || pop);
    ovf_d    = ovf_q || (push && full && !pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      ovf_d    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + RES_AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + RES_AW'(1);
      if (push_ok && !pop)      count_d = count_q + (RES_AW+1)'(1);
      else if (!push_ok && pop) count_d = count_q - (RES_AW+1)'(1);
    end
    res_valid_d = (count_d != '0);
    // Head register: the slot being written this cycle is not yet in
    // fifo_mem_q, so take it straight from the input when it becomes head.
    if (count_d == '0) begin
      res_data_d = '0;
    end else if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
      res_data_d = cpu_data_out;
    end else begin
      res_data_d = fifo_mem_q[rd_ptr_d];
    end
  end

  // Registered cpu-facing and status outputs derived from the next state
  always_comb begin
    prog_we     = load_we && (state_q == S_IDLE);
    cpu_n_rst_d = (state_d == S_PRE) || (state_d == S_ISSUE) || (state_d == S_DRAIN);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_q == S_DRAIN) && (state_d == S_IDLE);
    instr_d     = (state_d == S_ISSUE) ? prog_mem_q[idx_d] : '0;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_Rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      prev_q      <= '0;
      cpu_n_rst_q <= 1'b0;
      instr_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      prev_q      <= prev_d;
      cpu_n_rst_q <= cpu_n_rst_d;
      instr_q     <= instr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Program memory write port, open only while idle; survives reset
  always_ff @(posedge clk) begin
    if (prog_we) prog_mem_q[load_addr] <= load_data;
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= cpu_data_out;
  end

  assign cpu_n_Rst = cpu_n_rst_q;
  assign instr_out = instr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_cpu_prog_streamer.sv
// Directed bench for cpu_prog_streamer with a scoreboard queue of expected
// FIFO entries and a cycle-indexed model of the sequencer outputs.
module tb_cpu_prog_streamer;

  logic        clk = 1'b0;
  logic        n_Rst;
  logic        load_we;
  logic [3:0]  load_addr;
  logic [11:0] load_data;
  logic [4:0]  prog_len;
  logic        start;
  logic        cpu_n_Rst;
  logic [11:0] instr_out;
  logic [7:0]  cpu_data_out;
  logic [7:0]  res_data;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        done;
  logic        overflow;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [11:0] mem_m [16];
  logic [7:0]  sb [$];
  logic        ovf_m;
  int          ev_cyc [$];
  logic [7:0]  ev_val [$];

  always #5 clk = ~clk;

  cpu_prog_streamer #(
    .DEPTH(16), .ADDR_W(4), .HOLD_CYCLES(10), .RST_CYCLES(10), .RES_DEPTH(8)
  ) dut (
    .clk(clk), .n_Rst(n_Rst), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start),
    .cpu_n_Rst(cpu_n_Rst), .instr_out(instr_out), .cpu_data_out(cpu_data_out),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cpu_n_Rst"}, cpu_n_Rst, 0);
    chk({tag, "_instr"},     instr_out, 0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_done"},      done,      0);
    chk({tag, "_overflow"},  overflow,  0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"},  res_data,  0);
  endtask

  // One sequence: start in cycle 0, check every cycle up to done (+1).
  task automatic run(input int len, input int abort_cyc, input int poke_cyc, input bit wr_at_start);
    int eff;
    int done_c;
    logic [7:0]  prev_m;
    logic [11:0] ei;
    eff    = (len > 16) ? 16 : len;
    done_c = 31 + 10 * eff;
    prev_m = 8'h00;
    prog_len = len[4:0];
    start    = 1'b1;
    if (wr_at_start) begin
      load_we   = 1'b1;
      load_addr = 4'd3;
      load_data = 12'hABC;
      mem_m[3]  = 12'hABC;
    end
    sb.delete();
    ovf_m = 1'b0;
    step();
    start   = 1'b0;
    load_we = 1'b0;
    for (int c = 1; c <= done_c; c++) begin
      ei = (c >= 21 && c < 21 + 10 * eff) ? mem_m[(c - 21) / 10] : 12'h000;
      chk("cpu_n_Rst", cpu_n_Rst, (c >= 11 && c < done_c));
      chk("instr_out", instr_out, ei);
      chk("busy",      busy,      (c < done_c));
      chk("done",      done,      (c == done_c));
      chk("res_valid", res_valid, (sb.size() != 0));
      chk("res_data",  res_data,  (sb.size() != 0) ? sb[0] : 8'h00);
      chk("overflow",  overflow,  ovf_m);
      if (c == abort_cyc) begin
        n_Rst = 1'b0;
        step();
        n_Rst = 1'b1;
        chk_reset("abort");
        sb.delete();
        cpu_data_out = 8'h00;
        ev_cyc.delete();
        ev_val.delete();
        return;
      end
      for (int i = 0; i < ev_cyc.size(); i++)
        if (ev_cyc[i] == c) cpu_data_out = ev_val[i];
      if (c >= 11 && c < done_c && cpu_data_out != prev_m) begin
        prev_m = cpu_data_out;
        if (sb.size() < 8) sb.push_back(cpu_data_out);
        else ovf_m = 1'b1;
      end
      if (c == poke_cyc) begin
        load_we   = 1'b1;
        load_addr = 4'd1;
        load_data = 12'h000;
        start     = 1'b1;
        prog_len  = 5'd0;
      end
      step();
      if (c == poke_cyc) begin
        load_we = 1'b0;
        start   = 1'b0;
      end
    end
    chk("idle_busy",      busy,      0);
    chk("idle_done",      done,      0);
    chk("idle_cpu_n_Rst", cpu_n_Rst, 0);
    chk("idle_instr",     instr_out, 0);
    ev_cyc.delete();
    ev_val.delete();
    cpu_data_out = 8'h00;
  endtask

  // Pop every expected entry in order, then require the FIFO empty.
  task automatic drain();
    int n;
    n = sb.size();
    res_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("drain_valid", res_valid, 1);
      chk("drain_data",  res_data,  sb.pop_front());
      step();
    end
    res_ready = 1'b0;
    chk("drain_empty", res_valid, 0);
  endtask

  initial begin
    n_Rst = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    prog_len = '0; start = 1'b0; cpu_data_out = '0; res_ready = 1'b0;
    repeat (3) step();
    chk_reset("reset");
    n_Rst = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      mem_m[i]  = (i == 0) ? 12'h2FE : (i == 1) ? 12'hDFE : 12'h100 + 12'(i);
      load_we   = 1'b1;
      load_addr = i[3:0];
      load_data = mem_m[i];
      step();
    end
    load_we = 1'b0;

    // Two words, changes at 25 and 35, repeated value at 30
    ev_cyc = '{25, 30, 35};
    ev_val = '{8'h05, 8'h05, 8'hA0};
    run(2, 0, 0, 1'b0);
    drain();

    // Nine distinct changes into an 8-entry FIFO with no consumer
    for (int i = 0; i < 9; i++) begin
      ev_cyc.push_back(12 + i);
      ev_val.push_back(8'(i + 1));
    end
    run(2, 0, 0, 1'b0);
    chk("overflow_sticky", overflow, 1);

    // Empty program; busy-time write and start must be ignored
    run(0, 0, 15, 1'b0);

    // Length clamps to 16; write coinciding with start is accepted
    run(20, 0, 0, 1'b1);

    // Reset mid-run with an entry already queued
    ev_cyc = '{15};
    ev_val = '{8'h33};
    run(2, 25, 0, 1'b0);

    // Program memory intact after reset
    run(2, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpu_prog_streamer.md
Name: cpu_prog_streamer

Overview:
- Drives the cpu core from the other side of its interface: resets it, feeds it a stored program of 12-bit instruction words on its data_in, and captures every change of its 8-bit data_out into a result FIFO.
- Sits beside the cpu in the top-level and in benches, replacing hand-timed stimulus with a loadable, repeatable sequencer.
- The program memory is written through a simple write port while the block is idle.

Parameters:
- DEPTH, 16, program memory words (power of 2)
- ADDR_W, 4, log2(DEPTH)
- HOLD_CYCLES, 10, cycles each instruction word (and each idle-zero phase) is held on instr_out
- RST_CYCLES, 10, cycles cpu_n_Rst is held low after start
- RES_DEPTH, 8, result FIFO entries (power of 2)

Ports:
- clk  in  1  system clock, rising edge
- n_Rst  in  1  synchronous active-low reset
- load_we  in  1  program write strobe; ignored while busy
- load_addr  in  ADDR_W  program write address
- load_data  in  12  program write data
- prog_len  in  ADDR_W+1  number of words to issue; sampled at start; values above DEPTH clamp to DEPTH
- start  in  1  begin sequence; ignored while busy
- cpu_n_Rst  out  1  reset to the cpu, active low
- instr_out  out  12  instruction word to cpu data_in
- cpu_data_out  in  8  cpu data_out
- res_data  out  8  FIFO head
- res_valid  out  1  FIFO non-empty
- res_ready  in  1  consumer pop; pop occurs when res_valid&&res_ready
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of sequence
- overflow  out  1  sticky: a capture was dropped; cleared by start or reset

Behaviour:
- Clock and reset: one clock (clk); reset n_Rst is synchronous and active-low. All outputs are registered.
- Reset values: state IDLE, cpu_n_Rst=0, instr_out=0, busy=0, done=0, overflow=0, FIFO empty (res_valid=0, res_data=0).
- Reset does not clear program memory. Reset mid-sequence aborts immediately to these values.
- FSM states: IDLE, RST, PRE, ISSUE, DRAIN. A phase counter counts cycles within each state; a word index counts issued words.
- IDLE: cpu_n_Rst=0, instr_out=0. A start seen in cycle 0 gives state RST from cycle 1; overflow clears and the FIFO flushes at the same time.
- RST: cpu_n_Rst=0 for RST_CYCLES cycles, then PRE.
- PRE: cpu_n_Rst=1, instr_out=0 for HOLD_CYCLES cycles. Then ISSUE if the latched length is greater than 0, else DRAIN.
- ISSUE: instr_out=mem[k] for HOLD_CYCLES cycles per word, k=0..len-1, with no gap between words. After the last word, DRAIN.
- DRAIN: instr_out=0 for HOLD_CYCLES cycles. Next cycle: state IDLE, done=1 for that one cycle, busy=0, cpu_n_Rst=0.
- Capture runs in PRE, ISSUE and DRAIN:
  - The previous-value register loads 0 on entry to PRE.
  - Each cycle where cpu_data_out differs from the previous value, push cpu_data_out and update the previous value.
- FIFO push/pop rules:
  - Push is accepted if not full, or if a pop happens in the same cycle.
  - A push into a full FIFO with no pop drops the value and sets overflow.
  - Simultaneous push and pop when empty: the new value is stored and res_valid rises next cycle (no fall-through).
  - The FIFO keeps its contents after done until popped; start flushes it.
- Program writes: load_we while busy is ignored. A write in the same cycle as start is accepted, since the block is still IDLE.
- start while busy is ignored; prog_len is not re-sampled.

Test Plan:
- Load mem[0]=12'h2FE, mem[1]=12'hDFE, prog_len=2, start at cycle 0 -> cpu_n_Rst=0 in cycles 1-10; instr_out=0 in 11-20, 12'h2FE in 21-30, 12'hDFE in 31-40, 0 in 41-50; done=1 and busy=0 in cycle 51.
- Model cpu_data_out changing 0->8'h05 (cycle 25) ->8'h05 held ->8'hA0 (cycle 35) -> FIFO yields 8'h05 then 8'hA0, with res_valid one cycle after each change; a steady value produces no duplicate entries.
- res_ready=0 and 9 distinct changes with RES_DEPTH=8 -> first 8 retained in order, 9th dropped, overflow=1. Next start clears overflow and empties the FIFO.
- prog_len=0 -> PRE then DRAIN, instr_out never nonzero, done at cycle 31. prog_len=20 -> 16 words issued.
- n_Rst low at cycle 25 of a run -> next cycle all outputs at reset values, FIFO empty. Program memory is intact on rerun.
- load_we asserted while busy to mem[1]=12'h000 and start pulsed mid-run -> no effect: mem[1] still 12'hDFE on the next run, and the sequence timing is unchanged.
